// File: rtl/rfg_axis_protocol_pkg.sv
// Shared types and width helpers for the protocol FIFO AXI-Stream transmit framer.
package rfg_axis_protocol_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  localparam int BYTE_W = 8;
  localparam int PKT_CNT_W = 16;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/rfg_axis_protocol_tx_framer.sv
// Drains a show-ahead byte FIFO into an AXI-Stream master, closing packets on
// max length, idle timeout or flush. One byte is always held back to decide tlast.
module rfg_axis_protocol_tx_framer
  import rfg_axis_protocol_pkg::*;
#(
  parameter int MAX_PKT = 16,
  parameter int TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 fifo_empty,
  input  logic [BYTE_W-1:0]    fifo_read_value,
  output logic                 fifo_read,
  input  logic                 flush,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [BYTE_W-1:0]    m_axis_tdata,
  output logic                 m_axis_tlast,
  output logic                 busy,
  output logic [PKT_CNT_W-1:0] pkt_sent
);

  localparam int BCNT_W = cnt_w(MAX_PKT);
  localparam int ICNT_W = cnt_w(TIMEOUT);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(MAX_PKT - 1);
  localparam logic [ICNT_W-1:0] ICNT_LAST = ICNT_W'(TIMEOUT - 1);

  state_t                 state_r;
  logic [BYTE_W-1:0]      pend_r;
  logic [BCNT_W-1:0]      bcnt_r;
  logic [ICNT_W-1:0]      icnt_r;
  logic                   tvalid_r;
  logic [BYTE_W-1:0]      tdata_r;
  logic                   tlast_r;
  logic [PKT_CNT_W-1:0]   pkt_sent_r;
  logic                   hs_s;
  logic                   fifo_read_s;

  assign hs_s = tvalid_r & m_axis_tready;

  // Pop strobe: refill the hold register from IDLE, or right after a handshake.
  always_comb begin
    fifo_read_s = 1'b0;
    if (res) begin
      fifo_read_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: fifo_read_s = ~fifo_empty;
        ST_SEND: fifo_read_s = hs_s & ~fifo_empty;
        default: fifo_read_s = 1'b0;
      endcase
    end
  end

  // Framer FSM with held byte, byte/idle counters and registered AXIS outputs.
  always_ff @(posedge clk) begin
    if (res) begin
      state_r    <= ST_IDLE;
      pend_r     <= '0;
      bcnt_r     <= '0;
      icnt_r     <= '0;
      tvalid_r   <= 1'b0;
      tdata_r    <= '0;
      tlast_r    <= 1'b0;
      pkt_sent_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!fifo_empty) begin
            pend_r  <= fifo_read_value;
            icnt_r  <= '0;
            state_r <= ST_HOLD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          // A following byte in the FIFO proves this one is not the packet end.
          if ((bcnt_r == BCNT_LAST) || flush) begin
            tdata_r  <= pend_r;
            tlast_r  <= 1'b1;
            tvalid_r <= 1'b1;
            state_r  <= ST_SEND;
          end else if (!fifo_empty) begin
            tdata_r  <= pend_r;
            tlast_r  <= 1'b0;
            tvalid_r <= 1'b1;
            state_r  <= ST_SEND;
          end else if (icnt_r == ICNT_LAST) begin
            tdata_r  <= pend_r;
            tlast_r  <= 1'b1;
            tvalid_r <= 1'b1;
            state_r  <= ST_SEND;
          end else begin
            icnt_r <= icnt_r + ICNT_W'(1);
          end
        end
        ST_SEND: begin
          if (hs_s) begin
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
            if (tlast_r) begin
              bcnt_r     <= '0;
              pkt_sent_r <= pkt_sent_r + 16'd1;
            end else begin
              bcnt_r <= bcnt_r + BCNT_W'(1);
            end
            if (!fifo_empty) begin
              pend_r  <= fifo_read_value;
              icnt_r  <= '0;
              state_r <= ST_HOLD;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            state_r <= ST_SEND;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          tvalid_r <= 1'b0;
          tlast_r  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_read     = fifo_read_s;
  assign m_axis_tvalid = tvalid_r;
  assign m_axis_tdata  = tdata_r;
  assign m_axis_tlast  = tlast_r;
  assign busy          = (state_r != ST_IDLE);
  assign pkt_sent      = pkt_sent_r;

endmodule

// File: tb/tb_rfg_axis_protocol_tx_framer.sv
// Bench for the AXIS transmit framer: behavioural model plus directed literal checks.
module tb_rfg_axis_protocol_tx_framer;

  localparam int MAX_PKT = 16;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        res;
  logic        fifo_empty;
  logic [7:0]  fifo_read_value;
  logic        fifo_read;
  logic        flush;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tlast;
  logic        busy;
  logic [15:0] pkt_sent;

  always #5 clk = ~clk;

  rfg_axis_protocol_tx_framer #(.MAX_PKT(MAX_PKT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .res(res), .fifo_empty(fifo_empty), .fifo_read_value(fifo_read_value),
    .fifo_read(fifo_read), .flush(flush), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .busy(busy), .pkt_sent(pkt_sent)
  );

  // Show-ahead byte FIFO feeding the DUT; mem also records push order.
  logic [7:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty      = (wr_ptr == rd_ptr);
  assign fifo_read_value = mem[rd_ptr[9:0]];
  always @(posedge clk) if (fifo_read) rd_ptr <= rd_ptr + 1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model state: a byte held back, a beat on the wire, bytes already sent in the packet.
  bit          m_held = 1'b0, m_valid = 1'b0, m_last = 1'b0;
  logic [7:0]  m_byte = 8'h00, m_data = 8'h00;
  int          m_age = 0, m_len = 0;
  logic [15:0] m_sent = 16'd0;
  int          out_idx = 0, cur_len = 0;

  logic [7:0] log_data [0:1023];
  bit         log_last [0:1023];
  int         log_cyc  [0:1023];
  int         log_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic take_byte();
    m_held = 1'b1;
    m_byte = fifo_read_value;
    m_age  = 0;
  endtask

  task automatic emit(input bit last);
    m_valid = 1'b1;
    m_data  = m_byte;
    m_last  = last;
    m_held  = 1'b0;
  endtask

  // Model advance at each edge, then compare at the following falling edge.
  initial begin
    bit exp_read;
    forever begin
      @(posedge clk);
      cyc++;
      if (!res && m_axis_tvalid && m_axis_tready) begin
        chk("order", m_axis_tdata, mem[out_idx]);
        out_idx++;
        cur_len++;
        checks++;
        if (cur_len > MAX_PKT) begin
          errors++;
          $display("FAIL pkt_len actual=%0d expected<=%0d", cur_len, MAX_PKT);
        end
        if (m_axis_tlast) cur_len = 0;
        log_data[log_n] = m_axis_tdata;
        log_last[log_n] = m_axis_tlast;
        log_cyc[log_n]  = cyc;
        log_n++;
      end
      if (res) begin
        m_held = 1'b0; m_valid = 1'b0; m_last = 1'b0; m_data = 8'h00;
        m_age = 0; m_len = 0; m_sent = 16'd0;
        out_idx = rd_ptr; cur_len = 0;
      end else if (m_valid) begin
        if (m_axis_tready) begin
          m_valid = 1'b0;
          if (m_last) begin
            m_len  = 0;
            m_sent = m_sent + 16'd1;
          end else begin
            m_len++;
          end
          if (!fifo_empty) take_byte();
          else m_held = 1'b0;
        end
      end else if (m_held) begin
        if (m_len == MAX_PKT - 1 || flush) emit(1'b1);
        else if (!fifo_empty) emit(1'b0);
        else if (m_age == TIMEOUT - 1) emit(1'b1);
        else m_age++;
      end else if (!fifo_empty) begin
        take_byte();
      end
      @(negedge clk);
      exp_read = !res && !fifo_empty && (m_valid ? m_axis_tready : !m_held);
      chk("tvalid", m_axis_tvalid, m_valid);
      chk("busy", busy, m_held || m_valid);
      chk("pkt_sent", pkt_sent, m_sent);
      chk("fifo_read", fifo_read, exp_read);
      if (fifo_read && fifo_empty) chk("read_when_empty", 1, 0);
      if (m_valid) begin
        chk("tdata", m_axis_tdata, m_data);
        chk("tlast", m_axis_tlast, m_last);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr++;
  endtask

  task automatic wait_idle(input string name, input int budget, input bit rnd_ready);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      if (rnd_ready) m_axis_tready = 1'($urandom_range(0, 1));
      tick();
      if (wr_ptr == rd_ptr && !m_held && !m_valid) done = 1'b1;
    end
    if (!done) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic reset_pulse();
    res = 1'b1;
    tick();
    tick();
    res = 1'b0;
  endtask

  initial begin
    int base;
    int cnt;
    bit ok;
    res = 1'b1; m_axis_tready = 1'b0; flush = 1'b0;
    tick();
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt_sent", pkt_sent, 0);
    chk("rst_fifo_read", fifo_read, 0);
    tick();
    res = 1'b0;

    // Three bytes, last one closed by the idle timeout.
    m_axis_tready = 1'b1;
    base = log_n;
    push(8'h11); push(8'h22); push(8'h33);
    wait_idle("t1", 100, 1'b0);
    chk("t1_count", log_n - base, 3);
    chk("t1_b0", {log_data[base], 7'd0, log_last[base]}, 16'h1100);
    chk("t1_b1", {log_data[base+1], 7'd0, log_last[base+1]}, 16'h2200);
    chk("t1_b2", {log_data[base+2], 7'd0, log_last[base+2]}, 16'h3301);
    chk("t1_gap01", log_cyc[base+1] - log_cyc[base], 2);
    chk("t1_gap12", log_cyc[base+2] - log_cyc[base+1], 9);
    chk("t1_pkts", pkt_sent, 1);

    // 40 bytes: two full packets and a timed-out tail.
    reset_pulse();
    base = log_n;
    for (int k = 0; k < 40; k++) push(8'(k));
    wait_idle("t2", 400, 1'b0);
    chk("t2_count", log_n - base, 40);
    for (int k = 0; k < 40; k++) begin
      chk("t2_data", log_data[base+k], k);
      chk("t2_last", log_last[base+k], (k == 15 || k == 31 || k == 39) ? 1 : 0);
    end
    chk("t2_pkts", pkt_sent, 3);

    // Backpressure: beat held stable, single handshake on release.
    reset_pulse();
    m_axis_tready = 1'b0;
    base = log_n;
    push(8'hA5);
    repeat (20) tick();
    chk("t3_tvalid", m_axis_tvalid, 1);
    chk("t3_tdata", m_axis_tdata, 8'hA5);
    chk("t3_tlast", m_axis_tlast, 1);
    chk("t3_no_hs", log_n - base, 0);
    m_axis_tready = 1'b1;
    wait_idle("t3", 20, 1'b0);
    chk("t3_count", log_n - base, 1);
    chk("t3_pkts", pkt_sent, 1);

    // Flush closes the packet at the held byte before the timeout.
    reset_pulse();
    base = log_n;
    push(8'h01); push(8'h02);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      tick();
      if (log_n - base == 1) ok = 1'b1;
    end
    chk("t4_first_hs", ok, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle("t4a", 50, 1'b0);
    push(8'h03);
    wait_idle("t4b", 50, 1'b0);
    chk("t4_count", log_n - base, 3);
    chk("t4_b1", {log_data[base+1], 7'd0, log_last[base+1]}, 16'h0201);
    chk("t4_b2", {log_data[base+2], 7'd0, log_last[base+2]}, 16'h0301);
    chk("t4_gap", log_cyc[base+1] - log_cyc[base], 2);
    chk("t4_pkts", pkt_sent, 2);

    // Reset while a beat is waiting for tready.
    m_axis_tready = 1'b0;
    push(8'h77);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      tick();
      if (m_axis_tvalid) ok = 1'b1;
    end
    chk("t5_valid_seen", ok, 1);
    res = 1'b1;
    tick();
    chk("t5_tvalid", m_axis_tvalid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_pkts", pkt_sent, 0);
    res = 1'b0;
    m_axis_tready = 1'b1;
    repeat (4) tick();

    // Randomised ready with bursty pushes.
    reset_pulse();
    base = log_n;
    cnt = 0;
    while (cnt < 500) begin
      m_axis_tready = 1'($urandom_range(0, 1));
      for (int j = $urandom_range(0, 2); j > 0 && cnt < 500; j--) begin
        push(8'(cnt * 7 + 3));
        cnt++;
      end
      tick();
    end
    wait_idle("t6", 20000, 1'b1);
    chk("t6_count", log_n - base, 500);
    chk("t6_all_out", out_idx, wr_ptr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rfg_axis_protocol_tx_framer.md
Name: rfg_axis_protocol_tx_framer

Overview:
Reader/transmit end of the protocol byte FIFO. It drains response bytes from an 8-bit show-ahead FIFO and drives an AXI-Stream master with tvalid/tready/tlast. Bytes are framed into packets that close on a max length, an idle timeout or an explicit flush. It sits between the response FIFO and the host-facing AXIS link.

Parameters:
MAX_PKT, 16, max bytes per packet (>=2); tlast forced on byte MAX_PKT
TIMEOUT, 8, cycles the FIFO must stay empty while a byte is held before that byte goes out with tlast=1 (>=1)

Ports:
clk  in  1  clock
res  in  1  reset, synchronous, active-high
fifo_empty  in  1  FIFO empty flag
fifo_read_value  in  8  FIFO head byte, combinationally valid while !fifo_empty
fifo_read  out  1  pop strobe, one cycle per byte, never while fifo_empty
flush  in  1  level; closes the current packet at the held byte
m_axis_tvalid  out  1  AXIS valid
m_axis_tready  in  1  AXIS ready
m_axis_tdata  out  8  AXIS data
m_axis_tlast  out  1  AXIS last
busy  out  1  high in HOLD or SEND
pkt_sent  out  16  completed packet count (tlast handshakes), wraps at 2^16

Behaviour:
- Reset (res=1 at clk edge): state=IDLE; tvalid=0, tlast=0, tdata=0, fifo_read=0, busy=0, pkt_sent=0; byte/idle counters=0. A reset mid-packet drops the held byte (already popped). No partial tlast is emitted.
- Held byte register: pend. Byte-in-packet counter: bcnt, 0..MAX_PKT-1. Idle counter: icnt, 0..TIMEOUT-1.
- IDLE: if !fifo_empty -> fifo_read=1 (combinational, same cycle); pend<=fifo_read_value; icnt<=0; go HOLD.
- HOLD (evaluated each cycle, priority order):
  1. bcnt==MAX_PKT-1 or flush -> tdata<=pend, tlast<=1, tvalid<=1, go SEND.
  2. !fifo_empty -> tdata<=pend, tlast<=0, tvalid<=1, go SEND. Do not pop.
  3. icnt==TIMEOUT-1 -> tdata<=pend, tlast<=1, tvalid<=1, go SEND.
  4. else icnt<=icnt+1.
- SEND: tvalid=1. tdata and tlast stay stable until handshake. tvalid never drops without tready.
  - On handshake (tvalid & tready): tvalid<=0. If tlast: bcnt<=0, pkt_sent++, else bcnt++.
  - Then, same cycle: if !fifo_empty -> pop into pend, icnt<=0, go HOLD; else go IDLE.
  - A tlast=0 beat implies the FIFO held a byte at decision time. This block is the sole reader, so the FIFO is non-empty at the handshake.
- Latency: FIFO non-empty to first tvalid = 2 cycles (pop, then HOLD decision). Sustained rate = 1 byte per 2 cycles with tready=1.
- A packet never exceeds MAX_PKT bytes. An empty packet is never sent. tlast is always on a real byte.
- flush while IDLE has no effect. flush in SEND does not alter the beat in flight.
- busy = (state != IDLE).

Decomposition:
- Shared package rfg_axis_protocol_pkg:
  - state enum {IDLE, HOLD, SEND}
  - byte width constant 8
  - clog2-derived width helpers for bcnt/icnt
- No sub-module. The FIFO is instantiated by the parent; the block is a single FSM plus counters.

Test Plan:
- Reset, then push 3 bytes 0x11,0x22,0x33 back-to-back, tready=1 -> beats 0x11(l=0), 0x22(l=0), then 0x33(l=1) after 8 empty cycles; pkt_sent=1.
- Push 40 bytes 0x00..0x27, MAX_PKT=16, tready=1 -> packets of 16,16,8 bytes; tlast on 0x0F, 0x1F, 0x27 (last via timeout); pkt_sent=3.
- Push 0xA5, hold tready=0 for 20 cycles -> tvalid=1, tdata=0xA5, tlast=1 held stable throughout; exactly one handshake when tready rises.
- Push 0x01,0x02, assert flush while 0x02 is held -> 0x02 carries tlast=1 before the timeout; next byte 0x03 starts a new packet with bcnt=0.
- Assert res while in SEND with tvalid=1 -> next cycle tvalid=0, busy=0, pkt_sent=0; fifo_read never asserted while fifo_empty=1 (assertion checked over the whole run).
- Randomised tready, 500 bytes -> output byte order equals push order, no beat has more than 16 bytes in its packet, and no fifo_read occurs when empty.
